// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage bus bundling instruction memory, hazard/redirect controls and IF/ID outputs.
interface if_stage_if;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        pc_stall;
    logic        ifid_stall;
    logic        redirect;
    logic [8:0]  redirect_pc;
    logic        halt_req;
    logic [8:0]  ifid_curr_pc;
    logic [31:0] ifid_curr_instr;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;
    logic [15:0] bubble_count;
    modport master (
        output imem_addr, ifid_curr_pc, ifid_curr_instr, ifid_valid, halted, fetch_count, bubble_count,
        input  imem_rdata, pc_stall, ifid_stall, redirect, redirect_pc, halt_req
    );
    modport slave (
        input  imem_addr, ifid_curr_pc, ifid_curr_instr, ifid_valid, halted, fetch_count, bubble_count,
        output imem_rdata, pc_stall, ifid_stall, redirect, redirect_pc, halt_req
    );
endinterface

// File: rtl/if_stage.sv
// if_stage: RISC-V fetch stage owning the PC and IF/ID register, with stall/redirect/halt and saturating counters.
module if_stage #(
    parameter logic [31:0] BUBBLE_INSTR = 32'h0000_0000
) (
    input logic      clk,
    input logic      reset,
    if_stage_if.master bus
);
    typedef enum logic {RUN, HALT} state_t;
    state_t      state_q, state_d;
    logic [8:0]  pc_q, pc_d, cpc_q, cpc_d, tgt;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [15:0] fc_q, fc_d, bc_q, bc_d;
    logic        run, fetch, bubble;
    assign tgt = bus.redirect_pc & 9'h1FC;
    assign run = state_q == RUN;
    // halt and redirect override both stalls; ifid_stall alone behaves as a full hold
    assign bubble = run && (bus.halt_req || bus.redirect || (bus.pc_stall && !bus.ifid_stall));
    assign fetch = run && !bus.halt_req && !bus.redirect && !bus.pc_stall && !bus.ifid_stall;
    always_comb begin
        state_d = (run && bus.halt_req) ? HALT : state_q;
        pc_d    = (run && !bus.halt_req && bus.redirect) ? tgt : fetch ? pc_q + 9'd4 : pc_q;
        cpc_d   = bubble ? 9'd0 : fetch ? pc_q : cpc_q;
        instr_d = bubble ? BUBBLE_INSTR : fetch ? bus.imem_rdata : instr_q;
        valid_d = bubble ? 1'b0 : fetch ? 1'b1 : valid_q;
        fc_d    = fc_q + {15'd0, fetch && !(&fc_q)};
        bc_d    = bc_q + {15'd0, bubble && !(&bc_q)};
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= '0;
            cpc_q   <= '0;
            instr_q <= BUBBLE_INSTR;
            valid_q <= 1'b0;
            fc_q    <= '0;
            bc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cpc_q   <= cpc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fc_q    <= fc_d;
            bc_q    <= bc_d;
        end
    end
    assign bus.imem_addr       = pc_q;
    assign bus.ifid_curr_pc    = cpc_q;
    assign bus.ifid_curr_instr = instr_q;
    assign bus.ifid_valid      = valid_q;
    assign bus.halted          = state_q == HALT;
    assign bus.fetch_count     = fc_q;
    assign bus.bubble_count    = bc_q;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: table-driven scoreboard bench for if_stage plus async-reset and counter-saturation sequences.
module tb_if_stage;
    localparam logic [31:0] BUB = 32'h0000_0013;
    typedef struct {
        logic        ps, is, rd;
        logic [8:0]  rp;
        logic        hr;
        logic [8:0]  addr, cpc;
        logic [31:0] instr;
        logic        v, h;
        logic [15:0] fc, bc;
    } vec_t;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] imem [128];
    vec_t        vecs[$];
    vec_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    if_stage_if bus();
    if_stage #(.BUBBLE_INSTR(BUB)) dut (.clk(clk), .reset(reset), .bus(bus.master));
    always #5 clk = ~clk;
    assign bus.imem_rdata = imem[bus.imem_addr[8:2]];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask
    task automatic add(input logic ps, is, rd, input logic [8:0] rp, input logic hr,
                       input logic [8:0] addr, cpc, input logic [31:0] instr,
                       input logic v, h, input logic [15:0] fc, bc);
        vec_t t;
        t.ps = ps; t.is = is; t.rd = rd; t.rp = rp; t.hr = hr;
        t.addr = addr; t.cpc = cpc; t.instr = instr; t.v = v; t.h = h; t.fc = fc; t.bc = bc;
        vecs.push_back(t);
    endtask
    task automatic drive(input logic ps, is, rd, input logic [8:0] rp, input logic hr);
        bus.pc_stall = ps;
        bus.ifid_stall = is;
        bus.redirect = rd;
        bus.redirect_pc = rp;
        bus.halt_req = hr;
    endtask
    task automatic chk_all(input string p, input logic [8:0] addr, cpc, input logic [31:0] instr,
                           input logic v, h, input logic [15:0] fc, bc);
        chk({p, "_addr"}, 32'(bus.imem_addr), 32'(addr));
        chk({p, "_cpc"}, 32'(bus.ifid_curr_pc), 32'(cpc));
        chk({p, "_instr"}, bus.ifid_curr_instr, instr);
        chk({p, "_valid"}, 32'(bus.ifid_valid), 32'(v));
        chk({p, "_halted"}, 32'(bus.halted), 32'(h));
        chk({p, "_fcnt"}, 32'(bus.fetch_count), 32'(fc));
        chk({p, "_bcnt"}, 32'(bus.bubble_count), 32'(bc));
    endtask
    initial begin
        vec_t e;
        for (int i = 0; i < 128; i++) imem[i] = 32'h1000_0000 + 32'(i);
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h00A0_0113;
        imem[2] = 32'h0020_81B3;
        imem[3] = 32'h0000_0013;
        //   ps is rd rp      hr   addr    cpc     instr          v  h  fc bc
        add(0, 0, 0, 9'h000, 0, 9'h004, 9'h000, 32'h0050_0093, 1, 0, 1, 0);
        add(0, 0, 0, 9'h000, 0, 9'h008, 9'h004, 32'h00A0_0113, 1, 0, 2, 0);
        add(1, 1, 0, 9'h000, 0, 9'h008, 9'h004, 32'h00A0_0113, 1, 0, 2, 0);
        add(1, 1, 0, 9'h000, 0, 9'h008, 9'h004, 32'h00A0_0113, 1, 0, 2, 0);
        add(0, 0, 0, 9'h000, 0, 9'h00C, 9'h008, 32'h0020_81B3, 1, 0, 3, 0);
        add(1, 1, 1, 9'h02E, 0, 9'h02C, 9'h000, BUB,           0, 0, 3, 1);
        add(0, 0, 0, 9'h000, 0, 9'h030, 9'h02C, 32'h1000_000B, 1, 0, 4, 1);
        add(0, 1, 0, 9'h000, 0, 9'h030, 9'h02C, 32'h1000_000B, 1, 0, 4, 1);
        add(1, 0, 0, 9'h000, 0, 9'h030, 9'h000, BUB,           0, 0, 4, 2);
        add(0, 0, 0, 9'h000, 0, 9'h034, 9'h030, 32'h1000_000C, 1, 0, 5, 2);
        add(0, 0, 1, 9'h1FC, 0, 9'h1FC, 9'h000, BUB,           0, 0, 5, 3);
        add(0, 0, 0, 9'h000, 0, 9'h000, 9'h1FC, 32'h1000_007F, 1, 0, 6, 3);
        add(0, 0, 0, 9'h000, 0, 9'h004, 9'h000, 32'h0050_0093, 1, 0, 7, 3);
        add(0, 0, 1, 9'h017, 0, 9'h014, 9'h000, BUB,           0, 0, 7, 4);
        add(0, 0, 1, 9'h040, 1, 9'h014, 9'h000, BUB,           0, 1, 7, 5);
        for (int i = 0; i < 10; i++)
            add(i[1], i[2], i[0], 9'h080, i[0], 9'h014, 9'h000, BUB, 0, 1, 7, 5);
        drive(0, 0, 0, 9'h000, 0);
        #1 reset = 1'b1;
        #2 chk_all("reset", 9'h000, 9'h000, BUB, 0, 0, 16'd0, 16'd0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) @(negedge clk);
            drive(vecs[i].ps, vecs[i].is, vecs[i].rd, vecs[i].rp, vecs[i].hr);
            sb.push_back(vecs[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            chk_all($sformatf("row%0d", i), e.addr, e.cpc, e.instr, e.v, e.h, e.fc, e.bc);
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        drive(0, 0, 0, 9'h000, 0);
        #2 reset = 1'b1;
        #1 chk_all("async_rst", 9'h000, 9'h000, BUB, 0, 0, 16'd0, 16'd0);
        @(negedge clk) reset = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        chk("sat_fcnt", 32'(bus.fetch_count), 32'h0000_FFFF);
        chk("sat_bcnt", 32'(bus.bubble_count), 32'd0);
        chk("sat_valid", 32'(bus.ifid_valid), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        chk("sat_hold", 32'(bus.fetch_count), 32'h0000_FFFF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
